lsu_bram_adapter: RTL and testbench
===================================

LSU_BRAM_ADAPTER -- requirements
Module: lsu_bram_adapter

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, meaning the byte-address width presented to the data BRAM.
REQ-002 SHALL have ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- req_valid  in  1  CPU memory request valid.
- req_ready  out  1  adapter can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V width/sign code.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, LSB-justified.
- resp_valid  out  1  response available.
- resp_ready  in  1  CPU consumes the response.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  misaligned or illegal request.
- mem_wena  out  1  BRAM write enable.
- mem_ba  out  1  byte access.
- mem_ha  out  1  halfword access.
- mem_ua  out  1  unsigned load.
- mem_addr  out  ADDR_W  BRAM byte address.
- mem_din  out  32  BRAM write data.
- mem_dout  in  32  BRAM read data: byte at mem_addr in [7:0], little-endian, registered one cycle after address.

Function
REQ-003 SHALL implement the FSM states IDLE, ACCESS, CAPTURE and RESP.
REQ-004 SHALL drive req_ready=1 only in IDLE; a request is accepted on a clock edge where req_valid=1 and req_ready=1.
REQ-005 SHALL latch we, funct3, addr[ADDR_W-1:0] and wdata on accept; address bits above ADDR_W are ignored.
REQ-006 SHALL treat these funct3 codes as legal:
- loads: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu.
- stores: 000 sb, 001 sh, 010 sw.
- every other code, for loads or stores, is illegal.
REQ-007 SHALL flag a request as misaligned when it is halfword with addr[0]=1, or word with addr[1:0]!=0.
REQ-008 SHALL, on accepting an illegal or misaligned request, go IDLE->RESP with resp_err=1 and resp_rdata=0, and issue no BRAM access.
REQ-009 SHALL go IDLE->ACCESS on accepting a legal request.
REQ-010 SHALL drive mem_addr from the latched address in ACCESS and CAPTURE, and 0 otherwise.
REQ-011 SHALL drive mem_ba=(funct3[1:0]==00), mem_ha=(funct3[1:0]==01) and mem_ua=funct3[2] in ACCESS only, and 0 otherwise.
REQ-012 SHALL assert mem_wena=1 for exactly the one ACCESS cycle of a store, gated by rst=1, with mem_din=latched wdata; mem_din SHALL be 0 otherwise.
REQ-013 SHALL go ACCESS->RESP for a store, with resp_rdata=0 and resp_err=0.
REQ-014 SHALL go ACCESS->CAPTURE for a load.
REQ-015 SHALL, in CAPTURE, register mem_dout into resp_rdata:
- lb: sign-extend [7:0].
- lbu: zero-extend [7:0].
- lh: sign-extend [15:0].
- lhu: zero-extend [15:0].
- lw: all 32 bits.
REQ-016 SHALL go CAPTURE->RESP.
REQ-017 SHALL hold resp_valid=1 in RESP, with resp_rdata and resp_err stable, until resp_ready=1, then go RESP->IDLE.
REQ-018 SHALL make latency accept-edge-to-resp_valid equal to 3 cycles for loads, 2 for stores and 1 for errors, when resp_ready is tied high.
REQ-019 SHALL give a throughput of at most one request in flight; a new request is accepted no earlier than the cycle after the response handshake.
REQ-020 SHALL ignore req_* changes while not in IDLE.
REQ-021 SHALL need no address wrap: aligned accesses never span past byte 2^ADDR_W-1.

Reset
REQ-022 SHALL, on a clock edge with rst=0, enter IDLE and clear resp_rdata and resp_err.
REQ-023 SHALL hold these values while rst=0: resp_valid=0, req_ready=0, mem_wena=0, mem_ba=mem_ha=mem_ua=0, mem_addr=0, mem_din=0.
REQ-024 SHALL drop any in-flight transaction on reset mid-operation without issuing a response; a store in ACCESS while rst=0 SHALL NOT write.

Verification
REQ-025 Bench SHALL cover sw, addr 0x10, data 0xDEADBEEF -> one mem_wena pulse with mem_addr=0x010, mem_ba=mem_ha=0, then resp_valid 2 cycles after accept, rdata=0, err=0.
REQ-026 Bench SHALL cover lb/lbu at 0x11 with mem_dout=0x000000F0 -> lb resp_rdata=0xFFFFFFF0 and lbu resp_rdata=0x000000F0, each 3 cycles after accept.
REQ-027 Bench SHALL cover lh at 0x13 (misaligned) and funct3=011 -> resp_err=1 and rdata=0 one cycle after accept, with mem_wena, mem_ba and mem_ha all staying 0.
REQ-028 Bench SHALL cover lw at 0x20 with resp_ready held low 4 cycles -> resp_valid and rdata held stable, req_ready=0 throughout, and IDLE reached the cycle after resp_ready rises.
REQ-029 Bench SHALL cover rst=0 asserted during the ACCESS cycle of sw -> mem_wena=0, no resp_valid, and req_ready=1 the first cycle after rst returns to 1.
REQ-030 Bench SHALL cover back-to-back requests with req_valid held high -> exactly one accept per response handshake, with no request lost or duplicated.

Source files
------------

// File: rtl/lsu_bram_adapter.sv
// Bridges a valid/ready CPU load/store port onto a single-port BRAM with one-cycle registered reads.
// Illegal or misaligned requests are answered directly with an error and never touch the BRAM.
module lsu_bram_adapter #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              mem_wena,
    output logic              mem_ba,
    output logic              mem_ha,
    output logic              mem_ua,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_din,
    input  logic [31:0]       mem_dout
);

    typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, RESP} state_t;

    state_t              state_q, state_d;
    logic                we_q, we_d;
    logic [2:0]          funct3_q, funct3_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [31:0]         rdata_q, rdata_d;
    logic                err_q, err_d;

    logic                reqLegal;
    logic                reqMisaligned;
    logic [31:0]         loadData;
    logic                unusedAddrBits;

    assign unusedAddrBits = ^req_addr[31:ADDR_W];

    // Unsigned loads have no store counterpart, so funct3[2] is only legal without we.
    always_comb begin
        reqLegal = 1'b0;
        case (req_funct3)
            3'b000, 3'b001, 3'b010: reqLegal = 1'b1;
            3'b100, 3'b101:         reqLegal = !req_we;
            default:                reqLegal = 1'b0;
        endcase
        reqMisaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                        ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    end

    always_comb begin
        case (funct3_q)
            3'b000:  loadData = {{24{mem_dout[7]}}, mem_dout[7:0]};
            3'b100:  loadData = {24'b0, mem_dout[7:0]};
            3'b001:  loadData = {{16{mem_dout[15]}}, mem_dout[15:0]};
            3'b101:  loadData = {16'b0, mem_dout[15:0]};
            default: loadData = mem_dout;
        endcase
    end

    // BRAM-facing outputs are additionally gated by rst so nothing leaks while reset is held.
    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        funct3_d   = funct3_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        mem_wena   = 1'b0;
        mem_ba     = 1'b0;
        mem_ha     = 1'b0;
        mem_ua     = 1'b0;
        mem_addr   = '0;
        mem_din    = '0;
        case (state_q)
            IDLE: begin
                req_ready = rst;
                if (req_valid && rst) begin
                    we_d     = req_we;
                    funct3_d = req_funct3;
                    addr_d   = req_addr[ADDR_W-1:0];
                    wdata_d  = req_wdata;
                    rdata_d  = '0;
                    err_d    = !reqLegal || reqMisaligned;
                    state_d  = (!reqLegal || reqMisaligned) ? RESP : ACCESS;
                end
            end
            ACCESS: begin
                mem_addr = rst ? addr_q : '0;
                mem_ba   = rst && (funct3_q[1:0] == 2'b00);
                mem_ha   = rst && (funct3_q[1:0] == 2'b01);
                mem_ua   = rst && funct3_q[2];
                mem_wena = rst && we_q;
                mem_din  = (rst && we_q) ? wdata_q : '0;
                state_d  = we_q ? RESP : CAPTURE;
            end
            CAPTURE: begin
                mem_addr = rst ? addr_q : '0;
                rdata_d  = loadData;
                state_d  = RESP;
            end
            RESP: begin
                resp_valid = rst;
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            we_q     <= 1'b0;
            funct3_q <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

endmodule

// File: tb/tb_lsu_bram_adapter.sv
// Scoreboard bench for lsu_bram_adapter: a behavioural byte-wide BRAM model answers the adapter,
// expected responses are queued at issue time and compared when the response handshake happens.
module tb_lsu_bram_adapter;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_wena;
    logic        mem_ba;
    logic        mem_ha;
    logic        mem_ua;
    logic [9:0]  mem_addr;
    logic [31:0] mem_din;
    logic [31:0] memDout;

    logic [7:0]  bramMem [0:1023];
    exp_t        sbQueue [$];
    int          checkCount = 0;
    int          errorCount = 0;
    int          wenaCount = 0;
    int          accessCount = 0;
    int          acceptCount = 0;
    int          respCount = 0;
    logic [9:0]  lastWenaAddr;
    logic [31:0] lastDin;
    logic        lastBa, lastHa, lastUa;
    logic [9:0]  lastAccAddr;

    lsu_bram_adapter #(.ADDR_W(10)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_wena(mem_wena), .mem_ba(mem_ba), .mem_ha(mem_ha), .mem_ua(mem_ua),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(memDout)
    );

    always #5 clk = ~clk;

    // Byte-addressed little-endian BRAM with a one-cycle registered read port.
    always @(posedge clk) begin
        if (mem_wena) begin
            bramMem[mem_addr] <= mem_din[7:0];
            if (!mem_ba) bramMem[mem_addr + 10'd1] <= mem_din[15:8];
            if (!mem_ba && !mem_ha) begin
                bramMem[mem_addr + 10'd2] <= mem_din[23:16];
                bramMem[mem_addr + 10'd3] <= mem_din[31:24];
            end
        end
        memDout <= {bramMem[mem_addr + 10'd3], bramMem[mem_addr + 10'd2],
                    bramMem[mem_addr + 10'd1], bramMem[mem_addr]};
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Monitor: tracks BRAM activity and pops the scoreboard on every response handshake.
    always @(negedge clk) begin
        if (mem_wena) begin
            wenaCount    <= wenaCount + 1;
            lastWenaAddr <= mem_addr;
            lastDin      <= mem_din;
        end
        if (mem_wena || mem_ba || mem_ha || mem_ua) begin
            accessCount <= accessCount + 1;
            lastBa      <= mem_ba;
            lastHa      <= mem_ha;
            lastUa      <= mem_ua;
            lastAccAddr <= mem_addr;
        end
        if (rst && req_valid && req_ready) acceptCount <= acceptCount + 1;
        if (rst && resp_valid && resp_ready) begin
            respCount <= respCount + 1;
            if (sbQueue.size() == 0) begin
                checkOutput("sbUnderflow", sbQueue.size(), 1);
            end else begin
                exp_t e;
                e = sbQueue.pop_front();
                checkOutput("respRdata", resp_rdata, e.rdata);
                checkOutput("respErr", {31'b0, resp_err}, {31'b0, e.err});
            end
        end
    end

    task automatic waitAccept(input string tag);
        int n = 0;
        @(negedge clk);
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, "_accept"}, {31'b0, req_ready}, 32'd1);
    endtask

    // One complete transaction; holdCycles>0 keeps resp_ready low while the response waits.
    task automatic applyStimulus(input string tag, input logic we, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [31:0] expRdata, input logic expErr,
                                 input int expLat, input int holdCycles);
        int lat;
        logic [31:0] heldData;
        @(posedge clk);
        #1;
        sbQueue.push_back('{expRdata, expErr});
        resp_ready = (holdCycles == 0);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        waitAccept(tag);
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
        req_we     = 1'($urandom);
        req_funct3 = 3'($urandom);
        req_addr   = $urandom;
        req_wdata  = $urandom;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!resp_valid && lat < 20);
        checkOutput({tag, "_latency"}, lat, expLat);
        if (holdCycles > 0) begin
            heldData = resp_rdata;
            for (int k = 1; k < holdCycles; k++) begin
                @(negedge clk);
                checkOutput({tag, "_holdValid"}, {31'b0, resp_valid}, 32'd1);
                checkOutput({tag, "_holdData"}, resp_rdata, heldData);
                checkOutput({tag, "_holdReady"}, {31'b0, req_ready}, 32'd0);
            end
            @(posedge clk);
            #1;
            resp_ready = 1'b1;
            @(negedge clk);
        end
        @(negedge clk);
        checkOutput({tag, "_idle"}, {31'b0, req_ready}, 32'd1);
        checkOutput({tag, "_respDone"}, {31'b0, resp_valid}, 32'd0);
    endtask

    task automatic applyResetMidStore();
        int w0;
        @(posedge clk);
        #1;
        w0 = wenaCount;
        resp_ready = 1'b1;
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'b010;
        req_addr   = 32'h30;
        req_wdata  = 32'h12345678;
        waitAccept("rstMid");
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        rst       = 1'b0;
        @(negedge clk);
        checkOutput("rstMid_wena", {31'b0, mem_wena}, 32'd0);
        checkOutput("rstMid_respValid", {31'b0, resp_valid}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rstMid_ready", {31'b0, req_ready}, 32'd1);
        checkOutput("rstMid_noResp", {31'b0, resp_valid}, 32'd0);
        checkOutput("rstMid_noWrite", wenaCount - w0, 32'd0);
    endtask

    // Stores then loads back with req_valid never dropped between requests.
    task automatic applyStream();
        logic [31:0] dat [4];
        int acc0, rsp0, n;
        @(posedge clk);
        #1;
        acc0 = acceptCount;
        rsp0 = respCount;
        resp_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i < 4) begin
                dat[i]     = $urandom;
                req_we     = 1'b1;
                req_addr   = 32'h40 + 32'(4 * i);
                req_wdata  = dat[i];
                sbQueue.push_back('{32'h0, 1'b0});
            end else begin
                req_we     = 1'b0;
                req_addr   = 32'h40 + 32'(4 * (i - 4));
                req_wdata  = $urandom;
                sbQueue.push_back('{dat[i - 4], 1'b0});
            end
            req_funct3 = 3'b010;
            req_valid  = 1'b1;
            waitAccept("stream");
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        n = 0;
        while (sbQueue.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        checkOutput("streamAccepts", acceptCount - acc0, 32'd8);
        checkOutput("streamResps", respCount - rsp0, 32'd8);
    endtask

    initial begin
        int w0, a0;
        for (int i = 0; i < 1024; i++) bramMem[i] = 8'h00;
        bramMem[10'h11] = 8'hF0;
        bramMem[10'h20] = 8'h44;
        bramMem[10'h21] = 8'h33;
        bramMem[10'h22] = 8'h22;
        bramMem[10'h23] = 8'h11;
        rst        = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        resp_ready = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_ready", {31'b0, req_ready}, 32'd0);
        checkOutput("rst_respValid", {31'b0, resp_valid}, 32'd0);
        checkOutput("rst_rdata", resp_rdata, 32'd0);
        checkOutput("rst_err", {31'b0, resp_err}, 32'd0);
        checkOutput("rst_memAddr", {22'b0, mem_addr}, 32'd0);
        checkOutput("rst_wena", {31'b0, mem_wena}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        checkOutput("postRst_ready", {31'b0, req_ready}, 32'd1);

        applyStimulus("lb", 1'b0, 3'b000, 32'h11, 32'h0, 32'hFFFFFFF0, 1'b0, 3, 0);
        checkOutput("lb_ba", {31'b0, lastBa}, 32'd1);
        checkOutput("lb_ua", {31'b0, lastUa}, 32'd0);
        checkOutput("lb_addr", {22'b0, lastAccAddr}, 32'h11);
        applyStimulus("lbu", 1'b0, 3'b100, 32'h11, 32'h0, 32'h000000F0, 1'b0, 3, 0);
        checkOutput("lbu_ua", {31'b0, lastUa}, 32'd1);

        w0 = wenaCount;
        applyStimulus("sw", 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 2, 0);
        checkOutput("sw_pulses", wenaCount - w0, 32'd1);
        checkOutput("sw_addr", {22'b0, lastWenaAddr}, 32'h010);
        checkOutput("sw_din", lastDin, 32'hDEADBEEF);
        checkOutput("sw_ba", {31'b0, lastBa}, 32'd0);
        checkOutput("sw_ha", {31'b0, lastHa}, 32'd0);

        applyStimulus("lw10", 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 3, 0);
        applyStimulus("lh12", 1'b0, 3'b001, 32'h12, 32'h0, 32'hFFFFDEAD, 1'b0, 3, 0);
        checkOutput("lh_ha", {31'b0, lastHa}, 32'd1);
        applyStimulus("lhu10", 1'b0, 3'b101, 32'h10, 32'h0, 32'h0000BEEF, 1'b0, 3, 0);

        a0 = accessCount;
        w0 = wenaCount;
        applyStimulus("lhMis", 1'b0, 3'b001, 32'h13, 32'h0, 32'h0, 1'b1, 1, 0);
        applyStimulus("ld011", 1'b0, 3'b011, 32'h20, 32'h0, 32'h0, 1'b1, 1, 0);
        applyStimulus("st100", 1'b1, 3'b100, 32'h20, 32'hCAFEF00D, 32'h0, 1'b1, 1, 0);
        applyStimulus("swMis", 1'b1, 3'b010, 32'h22, 32'hCAFEF00D, 32'h0, 1'b1, 1, 0);
        checkOutput("err_noAccess", accessCount - a0, 32'd0);
        checkOutput("err_noWrite", wenaCount - w0, 32'd0);

        applyStimulus("lwHold", 1'b0, 3'b010, 32'h20, 32'h0, 32'h11223344, 1'b0, 3, 4);

        applyStimulus("sb", 1'b1, 3'b000, 32'h50, 32'h123456A5, 32'h0, 1'b0, 2, 0);
        applyStimulus("sh", 1'b1, 3'b001, 32'h52, 32'hFFFF7788, 32'h0, 1'b0, 2, 0);
        applyStimulus("lw50", 1'b0, 3'b010, 32'h50, 32'h0, 32'h778800A5, 1'b0, 3, 0);
        applyStimulus("lwHigh", 1'b0, 3'b010, 32'hFFFFFC10, 32'h0, 32'hDEADBEEF, 1'b0, 3, 0);

        applyResetMidStore();
        applyStimulus("lw30", 1'b0, 3'b010, 32'h30, 32'h0, 32'h0, 1'b0, 3, 0);

        applyStream();

        checkOutput("sbDrained", sbQueue.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
